// File: rtl/tnn_pkg.sv
// Shared definitions for the serial ternary neural-network engine:
// ternary code points, FSM state encoding and derived-width helpers.
package tnn_pkg;

    localparam logic [1:0] TC_ZERO = 2'b00;
    localparam logic [1:0] TC_POS  = 2'b01;
    localparam logic [1:0] TC_RSVD = 2'b10;
    localparam logic [1:0] TC_NEG  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC,
        ST_THR,
        ST_ARG,
        ST_DONE
    } state_t;

    // Signed width able to hold +/- feat_cnt * max_feature without overflow.
    function automatic int acc_width(input int feat_cnt, input int feat_bits);
        return $clog2(feat_cnt * ((1 << feat_bits) - 1) + 1) + 1;
    endfunction

    function automatic int score_width(input int hidden_cnt);
        return $clog2(hidden_cnt + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tnn_lane_mac.sv
// Combinational LANES-wide ternary multiply-accumulate: each lane adds
// +feature, -feature or nothing, and the lane terms are summed signed.
module tnn_lane_mac
    import tnn_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int FEAT_BITS = 4
) (
    input  logic [LANES*FEAT_BITS-1:0]                   feat,
    input  logic [2*LANES-1:0]                           codes,
    output logic signed [acc_width(LANES, FEAT_BITS)-1:0] sum
);

    localparam int MAC_W = acc_width(LANES, FEAT_BITS);

    logic signed [MAC_W-1:0] term;

    always_comb begin
        sum  = '0;
        term = '0;
        for (int k = 0; k < LANES; k++) begin
            term = signed'(MAC_W'(feat[k*FEAT_BITS +: FEAT_BITS]));
            case (codes[2*k +: 2])
                TC_POS:           sum = sum + term;
                TC_NEG:           sum = sum - term;
                TC_ZERO, TC_RSVD: sum = sum;
                default:          sum = sum;
            endcase
        end
    end

endmodule

// File: rtl/tnn_serial_engine.sv
// Sequential ternary classifier: streams layer-1/layer-2 weights from
// synchronous ROMs, thresholds each hidden neuron, scores classes, argmax.
module tnn_serial_engine
    import tnn_pkg::*;
#(
    parameter int FEAT_CNT   = 128,
    parameter int FEAT_BITS  = 4,
    parameter int HIDDEN_CNT = 40,
    parameter int CLASS_CNT  = 6,
    parameter int LANES      = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              in_valid,
    output logic                                              in_ready,
    input  logic [FEAT_CNT*FEAT_BITS-1:0]                     features,
    output logic [addr_width(HIDDEN_CNT*FEAT_CNT/LANES)-1:0]  w1_addr,
    input  logic [2*LANES-1:0]                                w1_data,
    output logic [addr_width(HIDDEN_CNT)-1:0]                 w2_addr,
    input  logic [2*CLASS_CNT-1:0]                            w2_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [addr_width(CLASS_CNT)-1:0]                  prediction,
    output logic                                              busy
);

    localparam int CHUNKS  = FEAT_CNT / LANES;
    localparam int ACC_W   = acc_width(FEAT_CNT, FEAT_BITS);
    localparam int MAC_W   = acc_width(LANES, FEAT_BITS);
    localparam int SCORE_W = score_width(HIDDEN_CNT);
    localparam int W1_AW   = addr_width(HIDDEN_CNT * CHUNKS);
    localparam int H_W     = addr_width(HIDDEN_CNT);
    localparam int C_W     = addr_width(CHUNKS);
    localparam int P_W     = addr_width(CLASS_CNT);

    localparam logic [C_W-1:0] C_LAST = C_W'(CHUNKS - 1);
    localparam logic [H_W-1:0] H_LAST = H_W'(HIDDEN_CNT - 1);
    localparam logic [P_W-1:0] J_LAST = P_W'(CLASS_CNT - 1);

    if (FEAT_CNT % LANES != 0) begin : g_lane_check
        $error("tnn_serial_engine: FEAT_CNT must be a multiple of LANES");
    end

    state_t                      state_q, state_d;
    logic [FEAT_CNT*FEAT_BITS-1:0] feat_q;
    logic                        primed_q;
    logic [C_W-1:0]              c_q;
    logic [H_W-1:0]              h_q;
    logic [P_W-1:0]              j_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic [SCORE_W-1:0]          score_q [CLASS_CNT];
    logic [SCORE_W-1:0]          best_q;
    logic [P_W-1:0]              best_idx_q;
    logic [P_W-1:0]              pred_q;
    logic [W1_AW-1:0]            w1_addr_q;

    logic [LANES*FEAT_BITS-1:0]  chunk_feat;
    logic signed [MAC_W-1:0]     mac_sum;
    logic                        last_chunk, last_hidden, last_class;
    logic                        hidden_bit, better;

    assign chunk_feat  = feat_q[int'(c_q) * (LANES*FEAT_BITS) +: LANES*FEAT_BITS];
    assign last_chunk  = (state_q == ST_ACC) && primed_q && (c_q == C_LAST);
    assign last_hidden = (h_q == H_LAST);
    assign last_class  = (j_q == J_LAST);
    assign hidden_bit  = ~acc_q[ACC_W-1];
    assign better      = (score_q[j_q] > best_q);

    tnn_lane_mac #(
        .LANES     (LANES),
        .FEAT_BITS (FEAT_BITS)
    ) u_lane_mac (
        .feat  (chunk_feat),
        .codes (w1_data),
        .sum   (mac_sum)
    );

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)   state_d = ST_ACC;
            ST_ACC:  if (last_chunk) state_d = ST_THR;
            ST_THR:  state_d = last_hidden ? ST_ARG : ST_ACC;
            ST_ARG:  if (last_class) state_d = ST_DONE;
            ST_DONE: if (out_ready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The ROM returns data one cycle after the address, so w1_addr runs one
    // chunk ahead of consumption; the first ACC cycle only primes the ROM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            feat_q     <= '0;
            primed_q   <= 1'b0;
            c_q        <= '0;
            h_q        <= '0;
            j_q        <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            pred_q     <= '0;
            w1_addr_q  <= '0;
            // NOTE: the score array is a handful of flops, not a RAM, so it is reset explicitly.
            for (int j = 0; j < CLASS_CNT; j++) score_q[j] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        feat_q    <= features;
                        primed_q  <= 1'b0;
                        c_q       <= '0;
                        h_q       <= '0;
                        acc_q     <= '0;
                        w1_addr_q <= '0;
                        for (int j = 0; j < CLASS_CNT; j++) score_q[j] <= '0;
                    end
                end
                ST_ACC: begin
                    if (!primed_q) begin
                        primed_q  <= 1'b1;
                        w1_addr_q <= w1_addr_q + 1'b1;
                    end else begin
                        acc_q <= acc_q + ACC_W'(mac_sum);
                        if (c_q == C_LAST) begin
                            c_q <= '0;
                            if (last_hidden) w1_addr_q <= '0;
                        end else begin
                            c_q       <= c_q + 1'b1;
                            w1_addr_q <= w1_addr_q + 1'b1;
                        end
                    end
                end
                ST_THR: begin
                    for (int j = 0; j < CLASS_CNT; j++) begin
                        if ((w2_data[2*j +: 2] == TC_POS &&  hidden_bit) ||
                            (w2_data[2*j +: 2] == TC_NEG && !hidden_bit))
                            score_q[j] <= score_q[j] + 1'b1;
                    end
                    acc_q <= '0;
                    if (!last_hidden) begin
                        h_q       <= h_q + 1'b1;
                        w1_addr_q <= w1_addr_q + 1'b1;
                    end else begin
                        h_q        <= '0;
                        j_q        <= '0;
                        best_q     <= '0;
                        best_idx_q <= '0;
                    end
                end
                ST_ARG: begin
                    // Strict greater-than keeps the lowest index on ties.
                    if (better) begin
                        best_q     <= score_q[j_q];
                        best_idx_q <= j_q;
                    end
                    if (last_class) begin
                        pred_q <= better ? j_q : best_idx_q;
                        j_q    <= '0;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign prediction = pred_q;
    assign w1_addr    = w1_addr_q;
    assign w2_addr    = h_q;

endmodule

// File: tb/tb_tnn_serial_engine.sv
// Self-checking bench for tnn_serial_engine: directed corner cases plus
// random vectors compared against a behavioural dot-product model.
module tb_tnn_serial_engine;
    import tnn_pkg::*;

    localparam int FEAT_CNT   = 128;
    localparam int FEAT_BITS  = 4;
    localparam int HIDDEN_CNT = 40;
    localparam int CLASS_CNT  = 6;
    localparam int LANES      = 8;
    localparam int CHUNKS     = FEAT_CNT / LANES;
    localparam int W1_DEPTH   = HIDDEN_CNT * CHUNKS;
    localparam int W1_AW      = addr_width(W1_DEPTH);
    localparam int W2_AW      = addr_width(HIDDEN_CNT);
    localparam int P_W        = addr_width(CLASS_CNT);
    localparam int LATENCY    = HIDDEN_CNT * (CHUNKS + 1) + CLASS_CNT + 2;
    localparam int LIMIT      = 2 * LATENCY;
    localparam int N_RANDOM   = 96;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic                          in_valid;
    logic                          in_ready;
    logic [FEAT_CNT*FEAT_BITS-1:0] features;
    logic [W1_AW-1:0]              w1_addr;
    logic [2*LANES-1:0]            w1_data;
    logic [W2_AW-1:0]              w2_addr;
    logic [2*CLASS_CNT-1:0]        w2_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [P_W-1:0]                prediction;
    logic                          busy;

    int checks = 0;
    int errors = 0;

    logic [1:0]         w1_code [HIDDEN_CNT][FEAT_CNT];
    logic [1:0]         w2_code [HIDDEN_CNT][CLASS_CNT];
    logic [2*LANES-1:0] w1_rom  [W1_DEPTH];
    logic [2*CLASS_CNT-1:0] w2_rom [HIDDEN_CNT];

    always #5 clk = ~clk;

    tnn_serial_engine #(
        .FEAT_CNT   (FEAT_CNT),
        .FEAT_BITS  (FEAT_BITS),
        .HIDDEN_CNT (HIDDEN_CNT),
        .CLASS_CNT  (CLASS_CNT),
        .LANES      (LANES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .features   (features),
        .w1_addr    (w1_addr),
        .w1_data    (w1_data),
        .w2_addr    (w2_addr),
        .w2_data    (w2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .prediction (prediction),
        .busy       (busy)
    );

    always @(posedge clk) begin
        w1_data <= (int'(w1_addr) < W1_DEPTH)   ? w1_rom[w1_addr] : '0;
        w2_data <= (int'(w2_addr) < HIDDEN_CNT) ? w2_rom[w2_addr] : '0;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int tern(input logic [1:0] code);
        if (code == 2'b01) return 1;
        if (code == 2'b11) return -1;
        return 0;
    endfunction

    // Reference: plain dot products per hidden neuron, sign threshold,
    // vote counting and a lowest-index argmax.
    function automatic int model_predict(input logic [FEAT_CNT*FEAT_BITS-1:0] f);
        int score [CLASS_CNT];
        int sum;
        int t;
        int best;
        bit hid;
        for (int j = 0; j < CLASS_CNT; j++) score[j] = 0;
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            sum = 0;
            for (int i = 0; i < FEAT_CNT; i++)
                sum += tern(w1_code[h][i]) * int'(f[i*FEAT_BITS +: FEAT_BITS]);
            hid = (sum >= 0);
            for (int j = 0; j < CLASS_CNT; j++) begin
                t = tern(w2_code[h][j]);
                if ((t == 1 && hid) || (t == -1 && !hid)) score[j]++;
            end
        end
        best = 0;
        for (int j = 1; j < CLASS_CNT; j++)
            if (score[j] > score[best]) best = j;
        return best;
    endfunction

    task automatic load_roms();
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            for (int c = 0; c < CHUNKS; c++)
                for (int k = 0; k < LANES; k++)
                    w1_rom[h*CHUNKS + c][2*k +: 2] = w1_code[h][c*LANES + k];
            for (int j = 0; j < CLASS_CNT; j++)
                w2_rom[h][2*j +: 2] = w2_code[h][j];
        end
    endtask

    task automatic fill_weights(input logic [1:0] c1, input logic [1:0] c2);
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            for (int i = 0; i < FEAT_CNT; i++) w1_code[h][i] = c1;
            for (int j = 0; j < CLASS_CNT; j++) w2_code[h][j] = c2;
        end
    endtask

    task automatic random_weights();
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            for (int i = 0; i < FEAT_CNT; i++) w1_code[h][i] = 2'($urandom_range(0, 3));
            for (int j = 0; j < CLASS_CNT; j++) w2_code[h][j] = 2'($urandom_range(0, 3));
        end
    endtask

    function automatic logic [FEAT_CNT*FEAT_BITS-1:0] random_features();
        logic [FEAT_CNT*FEAT_BITS-1:0] f;
        for (int i = 0; i < FEAT_CNT; i++) f[i*FEAT_BITS +: FEAT_BITS] = FEAT_BITS'($urandom_range(0, 15));
        return f;
    endfunction

    // One transaction: accept, wait for out_valid, optionally stall the
    // consumer for `hold` cycles, then complete the output handshake.
    task automatic run_vector(input logic [FEAT_CNT*FEAT_BITS-1:0] f, input int hold,
                              output int pred, output int lat);
        int n;
        out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        features = f;
        @(negedge clk);
        lat      = 1;
        in_valid = 1'b0;
        features = random_features();
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_low_busy", 32'(in_ready), 32'd0);
        while (!out_valid && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_in_time", 32'(out_valid), 32'd1);
        pred = int'(prediction);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_prediction", 32'(prediction), 32'(pred));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [FEAT_CNT*FEAT_BITS-1:0] f;
        int pred;
        int lat;
        bit seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        features  = '0;
        fill_weights(2'b00, 2'b00);
        load_roms();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_prediction", 32'(prediction), 32'd0);
        check("rst_w1_addr",    32'(w1_addr),    32'd0);
        check("rst_w2_addr",    32'(w2_addr),    32'd0);

        // All-zero weights: every hidden fires, all scores zero.
        run_vector(random_features(), 0, pred, lat);
        check("zero_w_pred", 32'(pred), 32'd0);
        check("zero_w_latency", 32'(lat), 32'(LATENCY));

        // Single negative weight drives hidden 0 low; class 3 votes for it.
        fill_weights(2'b00, 2'b00);
        w1_code[0][0] = 2'b11;
        w2_code[0][3] = 2'b11;
        load_roms();
        f = random_features();
        f[FEAT_BITS-1:0] = FEAT_BITS'(5);
        run_vector(f, 0, pred, lat);
        check("neg_feat0_pred", 32'(pred), 32'd3);

        // Classes 2 and 4 tie at 10 votes, class 5 trails, class 0 never scores.
        fill_weights(2'b00, 2'b00);
        for (int h = 0; h < HIDDEN_CNT; h++) begin
            w2_code[h][0] = 2'b11;
            if (h < 10) begin
                w2_code[h][2] = 2'b01;
                w2_code[h][4] = 2'b01;
            end
            if (h < 5) w2_code[h][5] = 2'b01;
        end
        load_roms();
        run_vector(random_features(), 0, pred, lat);
        check("tie_pred", 32'(pred), 32'd2);

        // Consumer stalls 50 cycles with the prediction held.
        run_vector(random_features(), 50, pred, lat);
        check("stall_pred", 32'(pred), 32'd2);

        // Extreme accumulator: every feature 15 at -1; class 1 collects all 40 votes.
        fill_weights(2'b11, 2'b00);
        for (int h = 0; h < HIDDEN_CNT; h++) w2_code[h][1] = 2'b11;
        load_roms();
        f = '1;
        run_vector(f, 0, pred, lat);
        check("max_neg_pred", 32'(pred), 32'd1);

        // Reset pulse 300 cycles into a run aborts it without any output.
        random_weights();
        load_roms();
        f = random_features();
        in_valid = 1'b1;
        features = f;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (299) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_w1_addr",   32'(w1_addr),   32'd0);
        check("mid_rst_w2_addr",   32'(w2_addr),   32'd0);
        seen = 1'b0;
        repeat (LATENCY + 100) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
        end
        check("no_output_after_rst", 32'(seen), 32'd0);
        run_vector(f, 0, pred, lat);
        check("post_rst_pred", 32'(pred), 32'(model_predict(f)));
        check("post_rst_latency", 32'(lat), 32'(LATENCY));

        // Random vectors against random weights, reserved code included.
        for (int v = 0; v < N_RANDOM; v++) begin
            if (v % 8 == 0) begin
                random_weights();
                load_roms();
            end
            f = random_features();
            run_vector(f, 0, pred, lat);
            check("rand_pred", 32'(pred), 32'(model_predict(f)));
            check("rand_latency", 32'(lat), 32'(LATENCY));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
